countdown_timer: RTL and testbench

- Loadable down-counter and timer. It is the count-down counterpart of the team's 4-bit enabled up-counter.
- It is loaded with a start value and decrements once per enabled clock. It flags expiry with a one-cycle pulse.
- In one-shot mode it holds a Done level until the consumer acknowledges it. In auto-reload mode it restarts from the loaded value.
- Used as the timeout and delay generator beside the up-counter in the lab datapath.

---
 rtl/countdown_timer.sv | 88 ++++++++
 tb/tb_countdown_timer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot (Done held until Ack) and auto-reload modes.
// Expired pulses for one cycle after each terminal decrement.
module countdown_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             En,
    input  logic             AutoReload,
    input  logic             Ack,
    output logic [WIDTH-1:0] Count,
    output logic             Busy,
    output logic             Done,
    output logic             Expired,
    output logic             Zero
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expired_q, expired_d;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        expired_d = 1'b0;
        if (Load) begin
            count_d  = LoadVal;
            reload_d = LoadVal;
            state_d  = (LoadVal != '0) ? StRun : StIdle;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (En) begin
                        // RUN always holds Count >= 1, so the decrement never borrows.
                        if (count_q == One) begin
                            expired_d = 1'b1;
                            if (AutoReload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = StDone;
                            end
                        end else begin
                            count_d = count_q - One;
                        end
                    end
                end
                StDone: begin
                    if (Ack) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            reload_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            expired_q <= expired_d;
        end
    end

    assign Count   = count_q;
    assign Busy    = (state_q == StRun);
    assign Done    = (state_q == StDone);
    assign Expired = expired_q;
    assign Zero    = (count_q == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed and randomized bench for countdown_timer against a behavioural timer model.
module tb_countdown_timer;

    localparam int W = 4;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         Load = 1'b0;
    logic [W-1:0] LoadVal = '0;
    logic         En = 1'b0;
    logic         AutoReload = 1'b0;
    logic         Ack = 1'b0;
    logic [W-1:0] Count;
    logic         Busy;
    logic         Done;
    logic         Expired;
    logic         Zero;

    countdown_timer #(.WIDTH(W)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Load       (Load),
        .LoadVal    (LoadVal),
        .En         (En),
        .AutoReload (AutoReload),
        .Ack        (Ack),
        .Count      (Count),
        .Busy       (Busy),
        .Done       (Done),
        .Expired    (Expired),
        .Zero       (Zero)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Model: value shown, value to restart from, and whether counting/finished.
    int m_cnt = 0;
    int m_rel = 0;
    bit m_running = 0;
    bit m_finished = 0;
    bit m_exp = 0;

    task automatic model_edge(input bit rst, input bit ld, input int lv, input bit en,
                              input bit ar, input bit ack);
        if (rst) begin
            m_cnt = 0; m_rel = 0; m_running = 0; m_finished = 0; m_exp = 0;
        end else if (ld) begin
            m_exp = 0;
            m_cnt = lv;
            m_rel = lv;
            m_running = (lv != 0);
            m_finished = 0;
        end else if (m_running && en) begin
            m_exp = (m_cnt == 1);
            if (m_cnt > 1) m_cnt = m_cnt - 1;
            else if (ar) m_cnt = m_rel;
            else begin
                m_cnt = 0; m_running = 0; m_finished = 1;
            end
        end else begin
            m_exp = 0;
            if (m_finished && ack) m_finished = 0;
        end
    endtask

    task automatic check(input string tag);
        logic [W-1:0] ec;
        ec = m_cnt[W-1:0];
        tests++;
        assert (Count === ec) else begin
            fails++; $error("FAIL %s Count observed=%0d expected=%0d", tag, Count, ec);
        end
        tests++;
        assert (Busy === m_running) else begin
            fails++; $error("FAIL %s Busy observed=%b expected=%b", tag, Busy, m_running);
        end
        tests++;
        assert (Done === m_finished) else begin
            fails++; $error("FAIL %s Done observed=%b expected=%b", tag, Done, m_finished);
        end
        tests++;
        assert (Expired === m_exp) else begin
            fails++; $error("FAIL %s Expired observed=%b expected=%b", tag, Expired, m_exp);
        end
        tests++;
        assert (Zero === (m_cnt == 0)) else begin
            fails++; $error("FAIL %s Zero observed=%b expected=%b", tag, Zero, (m_cnt == 0));
        end
    endtask

    task automatic expect_cnt(input int v, input string tag);
        logic [W-1:0] ev;
        ev = v[W-1:0];
        tests++;
        assert (Count === ev) else begin
            fails++; $error("FAIL %s const Count observed=%0d expected=%0d", tag, Count, ev);
        end
    endtask

    task automatic step(input bit rst, input bit ld, input int lv, input bit en,
                        input bit ar, input bit ack, input string tag);
        Rst = rst; Load = ld; LoadVal = lv[W-1:0]; En = en; AutoReload = ar; Ack = ack;
        @(posedge Clk);
        model_edge(rst, ld, lv, en, ar, ack);
        #1;
        check(tag);
    endtask

    initial begin
        int seq_a[6] = '{5, 4, 3, 2, 1, 0};
        int seq_b[8] = '{4, 3, 3, 2, 2, 1, 1, 0};
        int seq_c[9] = '{3, 2, 1, 3, 2, 1, 3, 2, 1};

        step(1, 0, 0, 0, 0, 0, "reset");
        step(1, 1, 7, 1, 0, 0, "rst_over_load0");
        step(1, 1, 7, 1, 0, 0, "rst_over_load1");

        // One-shot from 5
        step(0, 1, 5, 1, 0, 0, "load5");
        expect_cnt(seq_a[0], "load5");
        for (int i = 1; i < 6; i++) begin
            step(0, 0, 0, 1, 0, 0, "oneshot");
            expect_cnt(seq_a[i], "oneshot");
        end
        step(0, 0, 0, 1, 0, 0, "done_hold");
        step(0, 0, 0, 1, 0, 0, "done_hold2");
        step(0, 0, 0, 0, 0, 1, "ack");
        step(0, 0, 0, 1, 0, 1, "idle_ignores");
        expect_cnt(0, "idle_ignores");

        // En toggling from 4
        step(0, 1, 4, 1, 0, 0, "load4");
        expect_cnt(seq_b[0], "load4");
        for (int i = 1; i < 8; i++) begin
            step(0, 0, 0, (i % 2) == 1, 0, 0, "en_toggle");
            expect_cnt(seq_b[i], "en_toggle");
        end
        step(0, 0, 0, 0, 0, 1, "ack2");

        // Auto-reload from 3
        step(0, 1, 3, 1, 1, 0, "load3_ar");
        expect_cnt(seq_c[0], "load3_ar");
        for (int i = 1; i < 9; i++) begin
            step(0, 0, 0, 1, 1, 0, "autoreload");
            expect_cnt(seq_c[i], "autoreload");
        end

        // Reload mid-count, then reset mid-count
        step(0, 1, 6, 1, 0, 0, "load6");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, "run6");
        expect_cnt(2, "at2");
        step(0, 1, 9, 1, 0, 0, "reload9");
        expect_cnt(9, "reload9");
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 0, "run9");
        expect_cnt(2, "at2b");
        step(1, 0, 0, 1, 0, 0, "rst_mid");
        expect_cnt(0, "rst_mid");

        // Load zero, then Load+Ack in DONE
        step(0, 1, 0, 1, 0, 0, "load0");
        step(0, 0, 0, 1, 0, 0, "load0_idle");
        step(0, 1, 1, 1, 0, 0, "load1");
        step(0, 0, 0, 1, 0, 0, "to_done");
        step(0, 1, 2, 0, 0, 1, "load_ack");
        expect_cnt(2, "load_ack");

        // Random phase
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1) == 1, ($urandom_range(0, 3) == 0), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
